// File: rtl/reg_ctrl_if.sv
// Command, memory-read, register-file and OUTR-result signals of reg_ctrl.
// master = the controller side, slave = the environment side.
interface reg_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [1:0]        cmd_reg;
    logic [ADDR_W-1:0] cmd_addr;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rvalid;
    logic [1:0]        rf_instruction;
    logic [1:0]        rf_r_in;
    logic              rf_go;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              err;

    modport master (
        input  cmd_valid, cmd_op, cmd_reg, cmd_addr, mem_rvalid, out_ready,
        output cmd_ready, mem_rd, mem_addr, rf_instruction, rf_r_in, rf_go,
               out_valid, busy, err
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_reg, cmd_addr, mem_rvalid, out_ready,
        input  cmd_ready, mem_rd, mem_addr, rf_instruction, rf_r_in, rf_go,
               out_valid, busy, err
    );
endinterface

// File: rtl/reg_ctrl.sv
// Load/output sequencer between a command port, a word memory and a register file.
// Optional REG_CTRL_TIMEOUT_EN bounds memory waits to TMO_CYC cycles.
module reg_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int TMO_CYC = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    reg_ctrl_if.master bus
);
    localparam logic [1:0] OP_LOADS = 2'b00;
    localparam logic [1:0] OP_OUTR  = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE, S_RD1, S_WT1, S_RD2, S_WT2, S_WRITE, S_READ, S_HOLD
    } state_t;

    state_t            r_state, w_next;
    logic [1:0]        r_op, r_reg;
    logic [ADDR_W-1:0] r_addr;

    logic              r_mem_rd, r_rf_go, r_out_valid, r_busy, r_err;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [1:0]        r_rf_ins, r_rf_rin;

    logic              w_mem_rd, w_rf_go;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [1:0]        w_rf_ins, w_rf_rin;
    logic              w_accept, w_wait, w_stray, w_timeout;

    assign w_accept = (r_state == S_IDLE) && bus.cmd_valid;
    assign w_wait   = (r_state == S_WT1) || (r_state == S_WT2);
    assign w_stray  = bus.mem_rvalid && !w_wait;

`ifdef REG_CTRL_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    logic [TMO_W-1:0] r_tmo_cnt;

    // Counts consecutive wait cycles; the TMO_CYC-th empty one aborts.
    assign w_timeout = w_wait && !bus.mem_rvalid && (r_tmo_cnt == TMO_W'(TMO_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_tmo_cnt <= '0;
        else if (w_wait && !bus.mem_rvalid && !w_timeout)
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        else
            r_tmo_cnt <= '0;
    end
`else
    // Constant 0: memory waits are unbounded in this build.
    assign w_timeout = (TMO_CYC < 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.cmd_valid) w_next = (bus.cmd_op == OP_OUTR) ? S_READ : S_RD1;
            S_RD1:   w_next = S_WT1;
            S_WT1: begin
                if (w_timeout)            w_next = S_IDLE;
                else if (bus.mem_rvalid)  w_next = (r_op == OP_LOADS) ? S_WRITE : S_RD2;
            end
            S_RD2:   w_next = S_WT2;
            S_WT2: begin
                if (w_timeout)            w_next = S_IDLE;
                else if (bus.mem_rvalid)  w_next = S_WRITE;
            end
            S_WRITE: w_next = S_IDLE;
            S_READ:  w_next = S_HOLD;
            S_HOLD:  if (bus.out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_comb begin
        w_mem_rd   = 1'b0;
        w_mem_addr = '0;
        w_rf_go    = 1'b0;
        w_rf_ins   = 2'b00;
        w_rf_rin   = 2'b00;
        unique case (w_next)
            S_RD1: begin
                w_mem_rd   = 1'b1;
                w_mem_addr = bus.cmd_addr;
            end
            S_RD2: begin
                w_mem_rd   = 1'b1;
                w_mem_addr = r_addr + 1'b1;
            end
            S_WRITE: begin
                w_rf_go  = 1'b1;
                w_rf_ins = r_op;
                w_rf_rin = (r_op == OP_LOADS) ? r_reg : 2'b00;
            end
            S_READ: begin
                w_rf_go  = 1'b1;
                w_rf_ins = OP_OUTR;
                w_rf_rin = bus.cmd_reg;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op   <= 2'b00;
            r_reg  <= 2'b00;
            r_addr <= '0;
        end else if (w_accept) begin
            r_op   <= bus.cmd_op;
            r_reg  <= bus.cmd_reg;
            r_addr <= bus.cmd_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_rd    <= 1'b0;
            r_mem_addr  <= '0;
            r_rf_go     <= 1'b0;
            r_rf_ins    <= 2'b00;
            r_rf_rin    <= 2'b00;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_mem_rd    <= w_mem_rd;
            r_mem_addr  <= w_mem_addr;
            r_rf_go     <= w_rf_go;
            r_rf_ins    <= w_rf_ins;
            r_rf_rin    <= w_rf_rin;
            r_out_valid <= (w_next == S_HOLD);
            r_busy      <= (w_next != S_IDLE);
            r_err       <= r_err | w_stray | w_timeout;
        end
    end

    assign bus.cmd_ready      = (r_state == S_IDLE);
    assign bus.mem_rd         = r_mem_rd;
    assign bus.mem_addr       = r_mem_addr;
    assign bus.rf_go          = r_rf_go;
    assign bus.rf_instruction = r_rf_ins;
    assign bus.rf_r_in        = r_rf_rin;
    assign bus.out_valid      = r_out_valid;
    assign bus.busy           = r_busy;
    assign bus.err            = r_err;
endmodule

// File: tb/tb_reg_ctrl.sv
// Randomised bench for reg_ctrl: a per-cycle expectation timeline is built from
// transaction timing rules and compared against the DUT every cycle.
module tb_reg_ctrl;
    localparam int N   = 4096;
    localparam int BIG = 1 << 30;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_ctrl_if #(.ADDR_W(8)) bus ();
    reg_ctrl #(.ADDR_W(8), .TMO_CYC(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    // Expected-output timeline, indexed by cycle number.
    bit         e_busy [N];
    bit         e_mrd  [N];
    bit         e_go   [N];
    bit         e_ov   [N];
    logic [7:0] e_maddr[N];
    logic [1:0] e_ins  [N];
    logic [1:0] e_rin  [N];
    int         err_from  = BIG;
    int         idle_from = 0;
    bit         chk_en    = 1'b0;

    // Observed event log used by the directed literal checks.
    int         rd_cyc[$];
    logic [7:0] rd_addr[$];
    int         go_cyc[$];
    logic [1:0] go_ins[$];
    logic [1:0] go_rin[$];
    int         ov_cyc[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_rd) begin rd_cyc.push_back(cyc); rd_addr.push_back(bus.mem_addr); end
            if (bus.rf_go) begin
                go_cyc.push_back(cyc); go_ins.push_back(bus.rf_instruction); go_rin.push_back(bus.rf_r_in);
            end
            if (bus.out_valid) ov_cyc.push_back(cyc);
        end
        if (chk_en && rst_n && cyc < N) begin
            chk("cmd_ready", bus.cmd_ready, !e_busy[cyc]);
            chk("busy", bus.busy, e_busy[cyc]);
            chk("mem_rd", bus.mem_rd, e_mrd[cyc]);
            if (e_mrd[cyc]) chk("mem_addr", bus.mem_addr, e_maddr[cyc]);
            chk("rf_go", bus.rf_go, e_go[cyc]);
            if (e_go[cyc]) begin
                chk("rf_instruction", bus.rf_instruction, e_ins[cyc]);
                chk("rf_r_in", bus.rf_r_in, e_rin[cyc]);
            end
            chk("out_valid", bus.out_valid, e_ov[cyc]);
            chk("err", bus.err, cyc >= err_from);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        rd_cyc.delete(); rd_addr.delete();
        go_cyc.delete(); go_ins.delete(); go_rin.delete();
        ov_cyc.delete();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".cmd_ready"}, bus.cmd_ready, 1);
        chk({tag, ".mem_rd"}, bus.mem_rd, 0);
        chk({tag, ".mem_addr"}, bus.mem_addr, 0);
        chk({tag, ".rf_go"}, bus.rf_go, 0);
        chk({tag, ".rf_instruction"}, bus.rf_instruction, 0);
        chk({tag, ".rf_r_in"}, bus.rf_r_in, 0);
        chk({tag, ".out_valid"}, bus.out_valid, 0);
        chk({tag, ".busy"}, bus.busy, 0);
        chk({tag, ".err"}, bus.err, 0);
    endtask

    task automatic idle_cycles(input int n, input bit stray);
        int s;
        s = stray ? int'($urandom_range(n - 1, 0)) : -1;
        for (int i = 0; i < n; i++) begin
            bus.mem_rvalid = (i == s);
            if (i == s && cyc + 1 < err_from) err_from = cyc + 1;
            step();
        end
        bus.mem_rvalid = 1'b0;
    endtask

    // Offers a command now; if the DUT is busy it is held until the first idle cycle.
    // d1/d2: cycles from each mem_rd to its mem_rvalid; h: cycles out_ready stays low in HOLD.
    task automatic run_cmd(input logic [1:0] op, input logic [1:0] rg, input logic [7:0] addr,
                           input int d1, input int d2, input int h, output int c);
        int rv1, rv2, rdy, go, last, last_in;
        logic [7:0] a2;
        rv1 = -1; rv2 = -1; rdy = -1;
        c = (cyc > idle_from) ? cyc : idle_from;
        if (op == 2'b01) begin
            go = c + 1;
            e_ins[go] = 2'b01; e_rin[go] = rg;
            rdy = c + 2 + h;
            for (int t = c + 2; t <= rdy; t++) e_ov[t] = 1'b1;
            last = rdy; last_in = rdy;
        end else begin
            e_mrd[c + 1] = 1'b1; e_maddr[c + 1] = addr;
            rv1 = c + 1 + d1;
            if (op == 2'b00) begin
                go = rv1 + 1; last_in = rv1;
            end else begin
                a2 = addr + 8'd1;
                e_mrd[rv1 + 1] = 1'b1; e_maddr[rv1 + 1] = a2;
                rv2 = rv1 + 1 + d2;
                go = rv2 + 1; last_in = rv2;
            end
            e_ins[go] = op;
            e_rin[go] = (op == 2'b00) ? rg : 2'b00;
            last = go;
        end
        e_go[go] = 1'b1;
        for (int t = c + 1; t <= last; t++) e_busy[t] = 1'b1;
        idle_from = last + 1;

        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_reg = rg; bus.cmd_addr = addr;
        while (cyc < c) step();
        step();
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 2'($urandom); bus.cmd_reg = 2'($urandom); bus.cmd_addr = 8'($urandom);
        while (cyc <= last_in) begin
            bus.mem_rvalid = (cyc == rv1) || (cyc == rv2);
            bus.out_ready  = (cyc == rdy) || (cyc == c + 1 && $urandom_range(1, 0) == 1);
            step();
        end
        bus.mem_rvalid = 1'b0;
        bus.out_ready  = 1'b0;
    endtask

    task automatic rand_cmd(input bit stray);
        int c, gap;
        run_cmd(2'($urandom), 2'($urandom),
                ($urandom_range(3, 0) == 0) ? 8'hFF : 8'($urandom),
                $urandom_range(4, 1), $urandom_range(4, 1), $urandom_range(5, 0), c);
        gap = $urandom_range(2, 0);
        if (gap > 0) idle_cycles(gap, stray && ($urandom_range(5, 0) == 0));
    endtask

    task automatic hard_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        err_from = BIG;
        step();
    endtask

    // Starts a LOADD at an idle cycle with a one-cycle first read; returns the accept cycle.
    task automatic start_loadd_into_wt2(output int c);
        c = cyc;
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b11; bus.cmd_reg = 2'b00; bus.cmd_addr = 8'h40;
        step();
        bus.cmd_valid = 1'b0;
        step();
        bus.mem_rvalid = 1'b1;
        step();
        bus.mem_rvalid = 1'b0;
        while (cyc < c + 4) step();
    endtask

    initial begin
        int c;
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_reg = 2'b00; bus.cmd_addr = 8'h00;
        bus.mem_rvalid = 1'b0; bus.out_ready = 1'b0;

        #12;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        idle_from = cyc;
        chk_en = 1'b1;
        idle_cycles(2, 1'b0);

        // LOADS A3 @0x20, zero-wait memory
        clear_log();
        run_cmd(2'b00, 2'b10, 8'h20, 1, 1, 0, c);
        idle_cycles(3, 1'b0);
        chk("loads.n_rd", rd_cyc.size(), 1);
        if (rd_cyc.size() == 1) begin
            chk("loads.rd_ofs", rd_cyc[0] - c, 1);
            chk("loads.rd_addr", rd_addr[0], 8'h20);
        end
        chk("loads.n_go", go_cyc.size(), 1);
        if (go_cyc.size() == 1) begin
            chk("loads.go_ofs", go_cyc[0] - c, 3);
            chk("loads.go_ins", go_ins[0], 2'b00);
            chk("loads.go_rin", go_rin[0], 2'b10);
        end

        // LOADD @0xFF wraps to 0x00 for the second word
        clear_log();
        run_cmd(2'b11, 2'b01, 8'hFF, 1, 1, 0, c);
        idle_cycles(3, 1'b0);
        chk("loadd.n_rd", rd_cyc.size(), 2);
        if (rd_cyc.size() == 2) begin
            chk("loadd.rd0_addr", rd_addr[0], 8'hFF);
            chk("loadd.rd1_addr", rd_addr[1], 8'h00);
            chk("loadd.rd1_ofs", rd_cyc[1] - c, 3);
        end
        chk("loadd.n_go", go_cyc.size(), 1);
        if (go_cyc.size() == 1) begin
            chk("loadd.go_ofs", go_cyc[0] - c, 5);
            chk("loadd.go_ins", go_ins[0], 2'b11);
            chk("loadd.go_rin", go_rin[0], 2'b00);
        end

        // OUTR A4 with consumer stalling 5 cycles
        clear_log();
        run_cmd(2'b01, 2'b11, 8'h00, 1, 1, 5, c);
        idle_cycles(2, 1'b0);
        chk("outr.n_go", go_cyc.size(), 1);
        if (go_cyc.size() == 1) begin
            chk("outr.go_ofs", go_cyc[0] - c, 1);
            chk("outr.go_ins", go_ins[0], 2'b01);
            chk("outr.go_rin", go_rin[0], 2'b11);
        end
        chk("outr.n_ov", ov_cyc.size(), 6);
        if (ov_cyc.size() == 6) chk("outr.ov_first", ov_cyc[0] - c, 2);

        for (int i = 0; i < 30; i++) rand_cmd(1'b0);

        // Stray rvalid in IDLE, then good commands keep err up
        idle_cycles(4, 1'b0);
        idle_cycles(3, 1'b1);
        for (int i = 0; i < 3; i++) rand_cmd(1'b0);
        chk("sticky.err", bus.err, 1);

        for (int i = 0; i < 30; i++) rand_cmd(1'b1);
        idle_cycles(8, 1'b0);

        // Memory never answers the second read
        chk_en = 1'b0;
        hard_reset();
        clear_log();
        start_loadd_into_wt2(c);
        while (cyc < c + 19) step();
        chk("stall.err_c19", bus.err, 0);
        chk("stall.busy_c19", bus.busy, 1);
        step();
`ifdef REG_CTRL_TIMEOUT_EN
        chk("tmo.err", bus.err, 1);
        chk("tmo.busy", bus.busy, 0);
        chk("tmo.cmd_ready", bus.cmd_ready, 1);
`else
        for (int i = 0; i < 20; i++) step();
        chk("stall.busy_c40", bus.busy, 1);
        chk("stall.cmd_ready", bus.cmd_ready, 0);
`endif
        chk("stall.n_rd", rd_cyc.size(), 2);
        chk("stall.n_go", go_cyc.size(), 0);

        // Asynchronous reset while waiting for the second word
        hard_reset();
        start_loadd_into_wt2(c);
        chk("rst_wt2.busy_before", bus.busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst_wt2");
        #2;
        rst_n = 1'b1;
        err_from = BIG;
        clear_log();
        for (int i = 0; i < 10; i++) step();
        chk("rst_wt2.n_go", go_cyc.size(), 0);
        chk("rst_wt2.busy_after", bus.busy, 0);

        // Recovery under the per-cycle model
        idle_from = cyc;
        chk_en = 1'b1;
        for (int i = 0; i < 10; i++) rand_cmd(1'b0);
        idle_cycles(4, 1'b0);
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
